// File: rtl/mem_stage_pkg.sv
// Shared RV32I pipeline types for the MEM stage: control/data words, memory FSM
// states, load/store funct3 encodings and the access-alignment rule.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011
   } rv32i_opcode;

   typedef struct packed {
      rv32i_opcode opcode;
      logic [2:0]  funct3;
      logic        dmem_read;
      logic        dmem_write;
      logic [3:0]  mem_byte_enable;
      logic        load_regfile;
      logic [4:0]  rd;
   } rv32i_control_word;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu_out;
      logic [31:0] rs1_out;
      logic [31:0] rs2_out;
      logic [31:0] data_mdr;
   } rv32i_data_word;

   // Word accesses need off==0, halfword accesses need an even offset;
   // funct3[1:0] carries the width for both loads and stores.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (funct3[1:0])
         2'b10:   mis = (off != 2'b00);
         2'b01:   mis = off[0];
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane steering: store data/enables shifted onto byte lanes, and
// load data extracted from the read word with sign or zero extension.
module mem_stage_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rs2_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] word_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   output logic [31:0] mdr_o
);

   logic [31:0] shifted_s;

   assign shifted_s = word_i >> {off_i, 3'b000};

   // store path: replicate the datum on every lane, enable only the target lanes
   always_comb begin
      wdata_o = rs2_i;
      be_o    = 4'b1111;
      case (funct3_i)
         sb: begin
            wdata_o = {4{rs2_i[7:0]}};
            be_o    = be_i << off_i;
         end
         sh: begin
            wdata_o = {2{rs2_i[15:0]}};
            be_o    = be_i << off_i;
         end
         sw: begin
            wdata_o = rs2_i;
            be_o    = 4'b1111;
         end
         default: begin
            wdata_o = rs2_i;
            be_o    = 4'b1111;
         end
      endcase
   end

   // load path: the addressed byte/half is moved to bit 0 before extension
   always_comb begin
      mdr_o = word_i;
      case (funct3_i)
         lb:      mdr_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
         lh:      mdr_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
         lw:      mdr_o = word_i;
         lbu:     mdr_o = {24'h000000, shifted_s[7:0]};
         lhu:     mdr_o = {16'h0000, shifted_s[15:0]};
         default: mdr_o = word_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake, stalls the pipeline while
// an access is outstanding, aligns store/load data and keeps performance counters.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  rv32i_control_word stage_ctrl_i,
   input  rv32i_data_word    stage_data_i,
   input  logic              dmem_resp,
   input  logic [31:0]       dmem_rdata,
   output logic [31:0]       dmem_address,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_byte_enable,
   output rv32i_control_word stage_ctrl_o,
   output rv32i_data_word    stage_data_o,
   output logic              mem_stall,
   output logic              misalign,
   output logic [CNT_W-1:0]  perf_loads,
   output logic [CNT_W-1:0]  perf_stores,
   output logic [CNT_W-1:0]  perf_stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   mem_state_t       state_q;
   logic [31:0]      mdr_q;
   logic             op_wr_q;
   logic [CNT_W-1:0] loads_q;
   logic [CNT_W-1:0] stores_q;
   logic [CNT_W-1:0] stall_q;

   logic        mem_op_s;
   logic        is_wr_s;
   logic        is_ld_s;
   logic        misal_s;
   logic        op_ok_s;
   logic        req_s;
   logic [1:0]  off_s;
   logic [31:0] wdata_s;
   logic [31:0] ld_val_s;
   logic [3:0]  be_s;

   assign off_s = stage_data_i.alu_out[1:0];

   // decode the EX/MEM control word; read+write together counts as a write
   always_comb begin
      mem_op_s = stage_ctrl_i.dmem_read | stage_ctrl_i.dmem_write;
      is_wr_s  = stage_ctrl_i.dmem_write;
      is_ld_s  = stage_ctrl_i.dmem_read & ~stage_ctrl_i.dmem_write;
      misal_s  = mem_op_s & is_misaligned(stage_ctrl_i.funct3, off_s);
      op_ok_s  = mem_op_s & ~misal_s;
   end

   mem_stage_align u_align (
      .funct3_i (stage_ctrl_i.funct3),
      .off_i    (off_s),
      .rs2_i    (stage_data_i.rs2_out),
      .be_i     (stage_ctrl_i.mem_byte_enable),
      .word_i   (mdr_q),
      .wdata_o  (wdata_s),
      .be_o     (be_s),
      .mdr_o    (ld_val_s)
   );

   // request is live in IDLE with an aligned op and throughout BUSY; gating on
   // rst drops it the instant reset asserts, before the state register settles
   always_comb begin
      req_s = 1'b0;
      if (!rst) begin
         req_s = 1'b0;
      end else if (state_q == BUSY) begin
         req_s = 1'b1;
      end else if (state_q == IDLE) begin
         req_s = op_ok_s;
      end else begin
         req_s = 1'b0;
      end
   end

   // memory-side and pipeline-side control outputs
   always_comb begin
      dmem_address     = {stage_data_i.alu_out[31:2], 2'b00};
      dmem_read        = req_s & ~is_wr_s;
      dmem_write       = req_s & is_wr_s;
      dmem_wdata       = wdata_s;
      dmem_byte_enable = is_wr_s ? be_s : 4'b1111;
      mem_stall        = req_s;
      misalign         = rst & (state_q == IDLE) & misal_s;
   end

   // MEM/WB payload: loads only present data in DONE, misaligned ops carry zero
   always_comb begin
      stage_ctrl_o = stage_ctrl_i;
      stage_data_o = stage_data_i;
      if (misal_s) begin
         stage_data_o.data_mdr = 32'h0000_0000;
      end else if (is_ld_s) begin
         stage_data_o.data_mdr = (state_q == DONE) ? ld_val_s : 32'h0000_0000;
      end else begin
         stage_data_o.data_mdr = stage_data_i.data_mdr;
      end
   end

   // access FSM, read-data capture and performance counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         mdr_q    <= 32'h0000_0000;
         op_wr_q  <= 1'b0;
         loads_q  <= '0;
         stores_q <= '0;
         stall_q  <= '0;
      end else begin
         if (req_s) begin
            stall_q <= stall_q + CNT_ONE;
         end
         case (state_q)
            IDLE: begin
               if (op_ok_s) begin
                  op_wr_q <= is_wr_s;
                  if (dmem_resp) begin
                     mdr_q   <= dmem_rdata;
                     state_q <= DONE;
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (dmem_resp) begin
                  mdr_q   <= dmem_rdata;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (op_wr_q) begin
                  stores_q <= stores_q + CNT_ONE;
               end else begin
                  loads_q <= loads_q + CNT_ONE;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign perf_loads        = loads_q;
   assign perf_stores       = stores_q;
   assign perf_stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues ops and queues the expected
// result, a monitor pops and compares whenever the stage lets the pipeline advance.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   rv32i_control_word stage_ctrl_i;
   rv32i_data_word    stage_data_i;
   logic              dmem_resp = 1'b0;
   logic [31:0]       dmem_rdata = 32'h0;
   logic [31:0]       dmem_address;
   logic              dmem_read, dmem_write;
   logic [31:0]       dmem_wdata;
   logic [3:0]        dmem_byte_enable;
   rv32i_control_word stage_ctrl_o;
   rv32i_data_word    stage_data_o;
   logic              mem_stall, misalign;
   logic [31:0]       perf_loads, perf_stores, perf_stall_cycles;

   mem_stage #(.CNT_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .stage_ctrl_i      (stage_ctrl_i),
      .stage_data_i      (stage_data_i),
      .dmem_resp         (dmem_resp),
      .dmem_rdata        (dmem_rdata),
      .dmem_address      (dmem_address),
      .dmem_read         (dmem_read),
      .dmem_write        (dmem_write),
      .dmem_wdata        (dmem_wdata),
      .dmem_byte_enable  (dmem_byte_enable),
      .stage_ctrl_o      (stage_ctrl_o),
      .stage_data_o      (stage_data_o),
      .mem_stall         (mem_stall),
      .misalign          (misalign),
      .perf_loads        (perf_loads),
      .perf_stores       (perf_stores),
      .perf_stall_cycles (perf_stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        has_req;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] mdr;
      int          cycles;
      int          mis;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          done_cnt = 0;
   int          target = 0;
   int          resp_delay = 0;
   logic [31:0] mem_word = 32'h0;
   int          m_loads = 0, m_stores = 0, m_stall = 0;
   logic        last_req, last_wr;
   int          last_n;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, expv);
      end
   endtask

   // memory model: answers the Nth request cycle; random resp noise when idle
   int req_k = 0;
   always @(negedge clk) begin
      if (!rst) begin
         req_k = 0;
         dmem_resp = 1'b0;
      end else if (!(dmem_read || dmem_write)) begin
         req_k = 0;
         dmem_resp = 1'($urandom_range(0, 1));
         dmem_rdata = $urandom;
      end else begin
         dmem_resp = (req_k == resp_delay);
         dmem_rdata = dmem_resp ? mem_word : $urandom;
         req_k++;
      end
   end

   // monitor: checks every request cycle, pops the expectation when stall drops
   int cyc = 0, req_cyc = 0, mis_cnt = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         cyc = 0; req_cyc = 0; mis_cnt = 0;
      end else if (exp_q.size() != 0) begin
         e = exp_q[0];
         cyc++;
         if (misalign) mis_cnt++;
         if (dmem_read || dmem_write) begin
            req_cyc++;
            if (!e.has_req) begin
               chk("unexpected_req", {30'd0, dmem_read, dmem_write}, 32'd0);
            end else begin
               chk("req_addr", dmem_address, e.addr);
               chk("req_rw", {30'd0, dmem_read, dmem_write}, e.wr ? 32'd1 : 32'd2);
               chk("req_be", {28'd0, dmem_byte_enable}, {28'd0, e.be});
               if (e.wr) chk("req_wdata", dmem_wdata, e.wdata);
            end
         end
         if (!mem_stall) begin
            void'(exp_q.pop_front());
            chk("cycles", cyc, e.cycles);
            chk("req_cycles", req_cyc, e.has_req ? e.cycles - 1 : 0);
            chk("misalign_pulses", mis_cnt, e.mis);
            chk("data_mdr", stage_data_o.data_mdr, e.mdr);
            chk("ctrl_pass", {10'd0, stage_ctrl_o}, {10'd0, stage_ctrl_i});
            chk("alu_pass", stage_data_o.alu_out, stage_data_i.alu_out);
            cyc = 0; req_cyc = 0; mis_cnt = 0;
            done_cnt++;
         end
      end
   end

   // kinds: 0 lb 1 lh 2 lw 3 lbu 4 lhu 5 sb 6 sh 7 sw 8 alu
   task automatic apply(input int kind, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [31:0] mdr_in, input int n, input logic [31:0] word);
      rv32i_control_word c;
      rv32i_data_word    d;
      exp_t              e;
      logic [2:0]        f3;
      int                off, is_ld, is_st, mis;
      logic [31:0]       v;
      f3 = 3'd0;
      case (kind)
         0, 5: f3 = 3'd0;
         1, 6: f3 = 3'd1;
         2, 7: f3 = 3'd2;
         3:    f3 = 3'd4;
         4:    f3 = 3'd5;
         default: f3 = 3'd0;
      endcase
      is_ld = (kind < 5);
      is_st = (kind >= 5 && kind <= 7);
      off   = int'(alu % 4);
      mis   = ((is_ld || is_st) && (((kind == 2 || kind == 7) && off != 0) ||
               ((kind == 1 || kind == 4 || kind == 6) && (off % 2) == 1))) ? 1 : 0;
      c = '0;
      c.opcode = is_ld ? op_load : (is_st ? op_store : op_reg);
      c.funct3 = f3;
      c.dmem_read = is_ld[0];
      c.dmem_write = is_st[0];
      c.mem_byte_enable = (kind == 5) ? 4'b0001 : (kind == 6) ? 4'b0011 : 4'b1111;
      c.load_regfile = ~is_st[0];
      c.rd = 5'($urandom);
      d.pc = $urandom; d.alu_out = alu; d.rs1_out = $urandom; d.rs2_out = rs2; d.data_mdr = mdr_in;
      e.has_req = (is_ld || is_st) && !mis;
      e.wr      = is_st[0];
      e.addr    = alu - off;
      e.mis     = mis;
      e.cycles  = e.has_req ? n + 2 : 1;
      e.be      = 4'b1111;
      e.wdata   = rs2;
      if (kind == 5) begin e.be = 4'(1 << off); e.wdata = (rs2 % 256) * 32'h0101_0101; end
      if (kind == 6) begin e.be = 4'(3 << off); e.wdata = (rs2 % 65536) * 32'h0001_0001; end
      v = word / (32'd1 << (8 * off));
      if (mis) e.mdr = 32'h0;
      else if (!is_ld) e.mdr = mdr_in;
      else begin
         case (kind)
            0: e.mdr = (v % 256 >= 128) ? (v % 256) + 32'hFFFF_FF00 : v % 256;
            1: e.mdr = (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
            3: e.mdr = v % 256;
            4: e.mdr = v % 65536;
            default: e.mdr = word;
         endcase
      end
      last_req = e.has_req; last_wr = e.wr; last_n = n;
      resp_delay = n;
      mem_word = word;
      target = done_cnt + 1;
      exp_q.push_back(e);
      stage_ctrl_i = c;
      stage_data_i = d;
   endtask

   task automatic finish_op();
      int t = 0;
      while (done_cnt < target && t < 400) begin
         @(posedge clk);
         t++;
      end
      if (done_cnt < target) begin
         fails++;
         $display("FAIL timeout: op never completed, waited %0d cycles, required at most 400", t);
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
      if (last_req) begin
         m_stall += last_n + 1;
         if (last_wr) m_stores++; else m_loads++;
      end
      #1;
      chk("perf_loads", perf_loads, m_loads);
      chk("perf_stores", perf_stores, m_stores);
      chk("perf_stall", perf_stall_cycles, m_stall);
   endtask

   initial begin
      int kind;
      logic [31:0] alu;
      stage_ctrl_i = '0;
      stage_data_i = '0;
      #1;
      chk("rst_read", {31'd0, dmem_read}, 32'd0);
      chk("rst_write", {31'd0, dmem_write}, 32'd0);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      chk("rst_loads", perf_loads, 32'd0);
      chk("rst_stall_cnt", perf_stall_cycles, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      apply(2, 32'h0000_1000, 32'h0, 32'h0, 3, 32'hDEAD_BEEF);  finish_op();
      apply(0, 32'h0000_2003, 32'h0, 32'h0, 0, 32'h80FF_FFFF);  finish_op();
      apply(3, 32'h0000_2003, 32'h0, 32'h0, 0, 32'h80FF_FFFF);  finish_op();
      apply(6, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 2, 32'h0);  finish_op();
      apply(2, 32'h0000_4001, 32'h0, 32'h9999, 0, 32'h1111_2222); finish_op();

      // reset during the second BUSY cycle, then the held load re-requests
      apply(2, 32'h0000_5000, 32'h0, 32'h0, 1, 32'hCAFE_F00D);
      resp_delay = 1000;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rstmid_read", {31'd0, dmem_read}, 32'd0);
      chk("rstmid_stall", {31'd0, mem_stall}, 32'd0);
      chk("rstmid_loads", perf_loads, 32'd0);
      chk("rstmid_stores", perf_stores, 32'd0);
      chk("rstmid_stall_cnt", perf_stall_cycles, 32'd0);
      m_loads = 0; m_stores = 0; m_stall = 0;
      resp_delay = 1;
      @(posedge clk);
      #2 rst = 1'b1;
      finish_op();

      apply(8, 32'h0000_6000, 32'h0, 32'h0000_0055, 0, 32'h0);  finish_op();

      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 8);
         alu  = $urandom;
         apply(kind, alu, $urandom, $urandom, $urandom_range(0, 4), $urandom);
         finish_op();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
